// File: rtl/sarray_os_stream_if.sv
// Operand-in / result-out bundle of the output-stationary systolic array.
// The slave modport is the array; the master modport is the staging/post-store side.
interface sarray_os_stream_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 32
);
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                   left_in_valid_i;
  logic [ROWS*DW-1:0]     left_in_data_i;
  logic                   top_in_valid_i;
  logic [COLS*DW-1:0]     top_in_data_i;
  logic                   top_in_acc_i;
  logic                   top_in_precision_i;
  logic                   top_in_last_i;
  logic                   in_ready_o;
  logic                   bot_o_valid_o;
  logic                   bot_o_ready_i;
  logic [CNT_W-1:0]       bot_o_cnt_o;
  logic                   bot_o_last_o;
  logic [COLS*ACC_W-1:0]  bot_o_data_o;

  modport master (
    output left_in_valid_i, left_in_data_i,
    output top_in_valid_i, top_in_data_i, top_in_acc_i, top_in_precision_i, top_in_last_i,
    input  in_ready_o,
    input  bot_o_valid_o, bot_o_cnt_o, bot_o_last_o, bot_o_data_o,
    output bot_o_ready_i
  );

  modport slave (
    input  left_in_valid_i, left_in_data_i,
    input  top_in_valid_i, top_in_data_i, top_in_acc_i, top_in_precision_i, top_in_last_i,
    output in_ready_o,
    output bot_o_valid_o, bot_o_cnt_o, bot_o_last_o, bot_o_data_o,
    input  bot_o_ready_i
  );
endinterface

// File: rtl/sarray_os_stream.sv
// Output-stationary ROWSxCOLS systolic matrix-multiply array with internal operand skew
// and a row-at-a-time valid/ready drain of the accumulated C tile.
module sarray_os_stream #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  sarray_os_stream_if.slave bus
);
  localparam int CNT_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FL_W      = $clog2(FLUSH_LEN + 1);
  // A lane carries {vld, first, acc_mode, unsigned_mode, data}
  localparam int AW        = DW + 4;

  if (ACC_W < 2*DW + 2) begin : g_param_chk
    $error("ACC_W too narrow for a full (DW+1)x(DW+1) product");
  end

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [FL_W-1:0]  flush_cnt;
  logic [CNT_W-1:0] row_cnt;
  logic             tile_acc, tile_prec;
  logic             in_ready, accept, out_fire, row_last;
  logic             beat_first, beat_acc, beat_prec;

  logic [AW-1:0]          a_in   [ROWS];
  logic [AW-1:0]          a_edge [ROWS];
  logic [DW-1:0]          b_edge [COLS];
  logic [AW-1:0]          a_h    [ROWS][COLS];
  logic [DW-1:0]          b_v    [ROWS][COLS];
  logic signed [ACC_W-1:0] acc_q [ROWS][COLS];
  logic [COLS*ACC_W-1:0]  bot_data;

  function automatic logic signed [ACC_W-1:0] mul_ext(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic          uns
  );
    logic signed [DW:0]      ea, eb;
    logic signed [2*DW+1:0]  p;
    ea = uns ? $signed({1'b0, a}) : $signed({a[DW-1], a});
    eb = uns ? $signed({1'b0, b}) : $signed({b[DW-1], b});
    p  = ea * eb;
    return ACC_W'(p);
  endfunction

  assign in_ready = (state == IDLE) || (state == LOAD);
  assign accept   = bus.left_in_valid_i & bus.top_in_valid_i & in_ready;
  assign row_last = (row_cnt == CNT_W'(ROWS - 1));
  assign out_fire = (state == DRAIN) & bus.bot_o_ready_i;

  // The first beat's mode bits are used directly; later beats reuse the latched copy.
  assign beat_first = (state == IDLE);
  assign beat_acc   = beat_first ? bus.top_in_acc_i       : tile_acc;
  assign beat_prec  = beat_first ? bus.top_in_precision_i : tile_prec;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = bus.top_in_last_i ? FLUSH : LOAD;
      LOAD:  if (accept && bus.top_in_last_i) state_nxt = FLUSH;
      FLUSH: if (flush_cnt == FL_W'(FLUSH_LEN - 1)) state_nxt = DRAIN;
      DRAIN: if (out_fire && row_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      row_cnt   <= '0;
      tile_acc  <= 1'b0;
      tile_prec <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      if (out_fire) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
      if (accept && beat_first) begin
        tile_acc  <= bus.top_in_acc_i;
        tile_prec <= bus.top_in_precision_i;
      end
    end
  end

  // Stage p0: A row r is delayed r cycles, together with the beat's control bits.
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    assign a_in[r] = {accept, beat_first, beat_acc, beat_prec, bus.left_in_data_i[r*DW +: DW]};
    if (r == 0) begin : g_d0
      assign a_edge[r] = a_in[r];
    end else begin : g_dn
      logic [AW-1:0] sr_p [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < r; i++) sr_p[i] <= '0;
        end else begin
          sr_p[0] <= a_in[r];
          for (int i = 1; i < r; i++) sr_p[i] <= sr_p[i-1];
        end
      end
      assign a_edge[r] = sr_p[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    if (c == 0) begin : g_d0
      assign b_edge[c] = bus.top_in_data_i[c*DW +: DW];
    end else begin : g_dn
      logic [DW-1:0] sr_p [c];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < c; i++) sr_p[i] <= '0;
        end else begin
          sr_p[0] <= bus.top_in_data_i[c*DW +: DW];
          for (int i = 1; i < c; i++) sr_p[i] <= sr_p[i-1];
        end
      end
      assign b_edge[c] = sr_p[c-1];
    end
  end

  // Stage p1: PE grid; A and control move right, B moves down, one register per hop.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign a_h[r][0] = a_edge[r];
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic                    vld_p1, first_p1, accm_p1, uns_p1;
      logic [DW-1:0]           a_op;
      logic signed [ACC_W-1:0] acc_r;

      if (r == 0) begin : g_btop
        assign b_v[0][c] = b_edge[c];
      end

      assign {vld_p1, first_p1, accm_p1, uns_p1, a_op} = a_h[r][c];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_r <= '0;
        end else if (vld_p1) begin
          if (accm_p1 || !first_p1) acc_r <= acc_r + mul_ext(a_op, b_v[r][c], uns_p1);
          else                      acc_r <= mul_ext(a_op, b_v[r][c], uns_p1);
        end
      end
      assign acc_q[r][c] = acc_r;

      if (c < COLS - 1) begin : g_fwd_a
        logic [AW-1:0] a_p1;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) a_p1 <= '0;
          else     a_p1 <= a_h[r][c];
        end
        assign a_h[r][c+1] = a_p1;
      end

      if (r < ROWS - 1) begin : g_fwd_b
        logic [DW-1:0] b_p1;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) b_p1 <= '0;
          else     b_p1 <= b_v[r][c];
        end
        assign b_v[r+1][c] = b_p1;
      end
    end
  end

  // Stage p2: drain mux; accumulators are frozen in DRAIN so the row holds under backpressure.
  always_comb begin
    bot_data = '0;
    for (int c = 0; c < COLS; c++) bot_data[c*ACC_W +: ACC_W] = acc_q[row_cnt][c];
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.bot_o_valid_o = (state == DRAIN);
  assign bus.bot_o_cnt_o   = row_cnt;
  assign bus.bot_o_last_o  = (state == DRAIN) & row_last;
  assign bus.bot_o_data_o  = bot_data;
endmodule

// File: tb/tb_sarray_os_stream.sv
// Directed + randomized bench for sarray_os_stream against a plain matrix-multiply model.
module tb_sarray_os_stream;
  localparam int ROWS = 4, COLS = 4, DW = 8, ACC_W = 32;
  localparam int CW   = COLS * ACC_W;
  localparam int MAXK = 16;
  localparam int LAT  = ROWS + COLS;
  localparam int TMO  = 200;
  typedef logic [CW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sarray_os_stream_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(ACC_W)) bus ();
  sarray_os_stream #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [ROWS*DW-1:0] a_beats [MAXK];
  logic [COLS*DW-1:0] b_beats [MAXK];
  logic [ACC_W-1:0]   mc [ROWS][COLS];

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ext(input logic [DW-1:0] v, input bit uns);
    if (uns) return int'(v);
    return int'($signed(v));
  endfunction

  // C = (acc ? C : 0) + A x B over k beats, wrapping at ACC_W bits.
  task automatic model_tile(input int k, input bit accm, input bit uns);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (!accm) mc[r][c] = '0;
        for (int kk = 0; kk < k; kk++)
          mc[r][c] = mc[r][c] + ACC_W'(ext(a_beats[kk][r*DW +: DW], uns) *
                                      ext(b_beats[kk][c*DW +: DW], uns));
      end
  endtask

  function automatic vec_t row_exp(input int r);
    vec_t v = '0;
    for (int c = 0; c < COLS; c++) v[c*ACC_W +: ACC_W] = mc[r][c];
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mc[r][c] = '0;
  endtask

  task automatic fill_const(input int k, input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < k; i++) begin
      a_beats[i] = {ROWS{av}};
      b_beats[i] = {COLS{bv}};
    end
  endtask

  task automatic fill_rand(input int k);
    for (int i = 0; i < k; i++) begin
      a_beats[i] = $urandom;
      b_beats[i] = $urandom;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"}, vec_t'(bus.in_ready_o), vec_t'(1));
    check({tag, ".valid"},    vec_t'(bus.bot_o_valid_o), vec_t'(0));
    check({tag, ".cnt"},      vec_t'(bus.bot_o_cnt_o), vec_t'(0));
    check({tag, ".last"},     vec_t'(bus.bot_o_last_o), vec_t'(0));
    check({tag, ".data"},     bus.bot_o_data_o, vec_t'(0));
  endtask

  // Later beats carry random acc/precision values that the array must ignore.
  task automatic send_tile(input int k, input bit accm, input bit uns, input int gap, input bit one_side);
    int t;
    for (int i = 0; i < k; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bus.left_in_valid_i = one_side && (g == 0);
        bus.top_in_valid_i  = 1'b0;
        bus.left_in_data_i  = a_beats[i];
      end
      @(negedge clk);
      bus.left_in_valid_i    = 1'b1;
      bus.top_in_valid_i     = 1'b1;
      bus.left_in_data_i     = a_beats[i];
      bus.top_in_data_i      = b_beats[i];
      bus.top_in_acc_i       = (i == 0) ? accm : 1'($urandom_range(0, 1));
      bus.top_in_precision_i = (i == 0) ? uns  : 1'($urandom_range(0, 1));
      bus.top_in_last_i      = (i == k - 1);
      t = 0;
      while (!bus.in_ready_o && t < TMO) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("beat%0d.in_ready", i), vec_t'(bus.in_ready_o), vec_t'(1));
    end
    @(negedge clk);
    bus.left_in_valid_i = 1'b0;
    bus.top_in_valid_i  = 1'b0;
    bus.top_in_last_i   = 1'b0;
  endtask

  task automatic drain_check(input string tag, input int stall_row, input int stall_n, input int abort_row);
    int n = 1;
    while (!bus.bot_o_valid_o && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, vec_t'(n), vec_t'(LAT));
    for (int r = 0; r < ROWS; r++) begin
      check($sformatf("%s.r%0d.valid", tag, r), vec_t'(bus.bot_o_valid_o), vec_t'(1));
      check($sformatf("%s.r%0d.cnt", tag, r),   vec_t'(bus.bot_o_cnt_o), vec_t'(r));
      check($sformatf("%s.r%0d.last", tag, r),  vec_t'(bus.bot_o_last_o), vec_t'(r == ROWS - 1));
      check($sformatf("%s.r%0d.data", tag, r),  bus.bot_o_data_o, row_exp(r));
      if (r == abort_row) begin
        rst = 1'b1;
        #1;
        check_reset_outputs({tag, ".midrst"});
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (r == stall_row) begin
        bus.bot_o_ready_i = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check($sformatf("%s.stall%0d.valid", tag, s),    vec_t'(bus.bot_o_valid_o), vec_t'(1));
          check($sformatf("%s.stall%0d.cnt", tag, s),      vec_t'(bus.bot_o_cnt_o), vec_t'(r));
          check($sformatf("%s.stall%0d.data", tag, s),     bus.bot_o_data_o, row_exp(r));
          check($sformatf("%s.stall%0d.in_ready", tag, s), vec_t'(bus.in_ready_o), vec_t'(0));
        end
      end
      bus.bot_o_ready_i = 1'b1;
      @(negedge clk);
    end
    check({tag, ".done.valid"},    vec_t'(bus.bot_o_valid_o), vec_t'(0));
    check({tag, ".done.in_ready"}, vec_t'(bus.in_ready_o), vec_t'(1));
  endtask

  task automatic run_tile(input string tag, input int k, input bit accm, input bit uns);
    send_tile(k, accm, uns, 0, 1'b0);
    model_tile(k, accm, uns);
    drain_check(tag, -1, 0, -1);
  endtask

  initial begin
    int k;
    bit accm, uns;
    rst = 1'b1;
    bus.left_in_valid_i    = 1'b0;
    bus.left_in_data_i     = '0;
    bus.top_in_valid_i     = 1'b0;
    bus.top_in_data_i      = '0;
    bus.top_in_acc_i       = 1'b0;
    bus.top_in_precision_i = 1'b0;
    bus.top_in_last_i      = 1'b0;
    bus.bot_o_ready_i      = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // T1: single beat, rank-1 product.
    a_beats[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    b_beats[0] = {8'd1, 8'd1, 8'd1, 8'd1};
    run_tile("t1", 1, 1'b0, 1'b0);

    // T2: signed/unsigned extension corners.
    fill_const(4, 8'h80, 8'h80);
    run_tile("t2_80s", 4, 1'b0, 1'b0);
    run_tile("t2_80u", 4, 1'b0, 1'b1);
    fill_const(4, 8'hFF, 8'hFF);
    run_tile("t2_ffu", 4, 1'b0, 1'b1);
    run_tile("t2_ffs", 4, 1'b0, 1'b0);

    // T3: accumulate onto previous C, then overwrite.
    a_beats[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    b_beats[0] = {COLS{8'd1}};
    run_tile("t3a", 1, 1'b0, 1'b0);
    b_beats[0] = {COLS{8'd2}};
    run_tile("t3b", 1, 1'b1, 1'b0);
    b_beats[0] = {COLS{8'd1}};
    run_tile("t3c", 1, 1'b0, 1'b0);

    // T4: backpressure on row 1.
    fill_rand(3);
    send_tile(3, 1'b0, 1'b0, 0, 1'b0);
    model_tile(3, 1'b0, 1'b0);
    drain_check("t4", 1, 3, -1);

    // T5: gapped, one-sided-valid run against the gap-free result.
    fill_rand(4);
    uns = 1'($urandom_range(0, 1));
    run_tile("t5_ref", 4, 1'b0, uns);
    send_tile(4, 1'b0, uns, 2, 1'b1);
    model_tile(4, 1'b0, uns);
    drain_check("t5_gap", -1, 0, -1);

    // Randomized tiles, including accumulation chains.
    for (int t = 0; t < 8; t++) begin
      k    = $urandom_range(1, 6);
      accm = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      fill_rand(k);
      run_tile($sformatf("rnd%0d", t), k, accm, uns);
    end

    // T6: reset in the middle of the drain, then accumulate from cleared C.
    fill_rand(2);
    send_tile(2, 1'b1, 1'b0, 0, 1'b0);
    model_tile(2, 1'b1, 1'b0);
    drain_check("t6_abort", -1, 0, 2);
    fill_const(1, 8'd1, 8'd5);
    run_tile("t6_after", 1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
